// File: rtl/usb_ft1248_device_if.sv
// System clock/reset bundle for the FT1248 device; the device only sees modport "sys".
interface if_system;
  logic clk;
  logic reset;

  modport sys (input clk, input reset);
endinterface

// File: rtl/usb_ft1248_device.sv
// FT1248 slave: 4-bit nibble bus from an external initiator bridged to two byte FIFOs on sys.clk.
// Optional transfer counters are built when `define USB_FT1248_DEVICE_STATS_EN is set.

module intel_fifo_8 #(
  parameter int AW = 4
) (
  input  logic       i_clk,
  input  logic       i_sclr,
  input  logic [7:0] i_data,
  input  logic       i_wrreq,
  input  logic       i_rdreq,
  output logic [7:0] o_q,
  output logic       o_empty,
  output logic       o_full
);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(2**AW);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    r_mem [0:2**AW-1];
  logic [7:0]    r_q;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH);
  assign w_wr    = i_wrreq & ~o_full;
  assign w_rd    = i_rdreq & ~o_empty;
  assign o_q     = r_q;

  // Storage and read port stay unreset so they map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
    if (w_rd) r_q <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module usb_ft1248_device #(
  parameter int FIFO_AW = 4
) (
  if_system.sys      sys,
  input  logic       usb_clk,
  input  logic       usb_cs,
  output logic       usb_miso,
  inout  wire  [3:0] usb_miosi,
  output logic       usb_pwren,
  input  logic       enable,
  input  logic       rx_flush,
  input  logic       rx_read,
  output logic       rx_empty,
  output logic [7:0] rx_rdata,
  input  logic       tx_flush,
  input  logic       tx_write,
  output logic       tx_full,
  input  logic [7:0] tx_wdata,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count
);
  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_LO, S_CMD_HI, S_TURN, S_ACK, S_DATA, S_WAIT
  } state_t;

  state_t     r_state;
  logic [2:0] r_uclk_sync;
  logic [2:0] r_cs_sync;
  logic       r_miso;
  logic       r_miosi_oe;
  logic [3:0] r_miosi_q;
  logic       r_pwren;
  logic [7:0] r_cmd;
  logic       r_ack;
  logic       r_nib;
  logic [3:0] r_lo_nib;
  logic       r_rx_wrreq;
  logic [7:0] r_rx_wdata;
  logic       r_tx_rdreq;
  logic       r_tx_load;
  logic [7:0] r_tx_byte;
  logic       r_tx_have;

  logic       w_uclk_rise;
  logic       w_uclk_fall;
  logic       w_cs_hi;
  logic       w_cs_fall;
  logic       w_rx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_q;
  logic       w_ack_ok;

  intel_fifo_8 #(.AW(FIFO_AW)) u_rx_fifo (
    .i_clk   (sys.clk),
    .i_sclr  (sys.reset | rx_flush),
    .i_data  (r_rx_wdata),
    .i_wrreq (r_rx_wrreq),
    .i_rdreq (rx_read),
    .o_q     (rx_rdata),
    .o_empty (rx_empty),
    .o_full  (w_rx_full)
  );

  intel_fifo_8 #(.AW(FIFO_AW)) u_tx_fifo (
    .i_clk   (sys.clk),
    .i_sclr  (sys.reset | tx_flush),
    .i_data  (tx_wdata),
    .i_wrreq (tx_write),
    .i_rdreq (r_tx_rdreq),
    .o_q     (w_tx_q),
    .o_empty (w_tx_empty),
    .o_full  (tx_full)
  );

  assign usb_miso    = r_miso;
  assign usb_pwren   = r_pwren;
  assign usb_miosi   = r_miosi_oe ? r_miosi_q : 4'bz;
  assign w_uclk_rise = r_uclk_sync[1] & ~r_uclk_sync[2];
  assign w_uclk_fall = ~r_uclk_sync[1] & r_uclk_sync[2];
  assign w_cs_hi     = r_cs_sync[1];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_ack_ok    = enable && (((r_cmd == CMD_READ) && !w_tx_empty) ||
                                  ((r_cmd == CMD_WRITE) && !w_rx_full));

  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      r_uclk_sync <= '0;
      r_cs_sync   <= '0;
      r_pwren     <= 1'b1;
    end else begin
      r_uclk_sync <= {r_uclk_sync[1:0], usb_clk};
      r_cs_sync   <= {r_cs_sync[1:0], usb_cs};
      r_pwren     <= ~enable;
    end
  end

  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      r_state    <= S_IDLE;
      r_miso     <= 1'b1;
      r_miosi_oe <= 1'b0;
      r_miosi_q  <= '0;
      r_cmd      <= '0;
      r_ack      <= 1'b0;
      r_nib      <= 1'b0;
      r_lo_nib   <= '0;
      r_rx_wrreq <= 1'b0;
      r_rx_wdata <= '0;
      r_tx_rdreq <= 1'b0;
      r_tx_load  <= 1'b0;
      r_tx_byte  <= '0;
      r_tx_have  <= 1'b0;
    end else begin
      r_rx_wrreq <= 1'b0;
      r_tx_rdreq <= 1'b0;
      // FIFO data appears one cycle after the pop; latch it the cycle after that.
      r_tx_load  <= r_tx_rdreq & ~w_tx_empty;
      if (r_tx_load) begin
        r_tx_byte <= w_tx_q;
        r_tx_have <= 1'b1;
      end
      if (w_cs_hi && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_miso     <= 1'b1;
        r_miosi_oe <= 1'b0;
        r_nib      <= 1'b0;
        r_tx_have  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_miso     <= 1'b1;
            r_miosi_oe <= 1'b0;
            r_tx_have  <= 1'b0;
            if (w_cs_fall) r_state <= S_CMD_LO;
          end
          S_CMD_LO: if (w_uclk_rise) begin
            r_cmd[3:0] <= usb_miosi;
            r_state    <= S_CMD_HI;
          end
          S_CMD_HI: if (w_uclk_rise) begin
            r_cmd[7:4] <= usb_miosi;
            r_state    <= S_TURN;
          end
          S_TURN: if (w_uclk_fall) begin
            r_ack   <= w_ack_ok;
            r_miso  <= ~w_ack_ok;
            r_state <= S_ACK;
          end
          S_ACK: if (w_uclk_rise) begin
            r_nib <= 1'b0;
            if (r_ack) begin
              r_state <= S_DATA;
              if (r_cmd == CMD_READ) r_tx_rdreq <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
          S_DATA: begin
            if (r_cmd == CMD_WRITE) begin
              if (w_uclk_fall && !r_nib) begin
                r_miso <= w_rx_full;
                if (w_rx_full) r_state <= S_WAIT;
              end
              if (w_uclk_rise) begin
                r_nib <= ~r_nib;
                if (!r_nib) begin
                  r_lo_nib <= usb_miosi;
                end else begin
                  r_rx_wrreq <= 1'b1;
                  r_rx_wdata <= {usb_miosi, r_lo_nib};
                end
              end
            end else if (w_uclk_fall) begin
              if (!r_nib) begin
                if (r_tx_have) begin
                  r_miosi_q  <= r_tx_byte[3:0];
                  r_miosi_oe <= 1'b1;
                  r_miso     <= 1'b0;
                  r_nib      <= 1'b1;
                end else begin
                  r_miso     <= 1'b1;
                  r_miosi_oe <= 1'b0;
                  r_state    <= S_WAIT;
                end
              end else begin
                r_miosi_q <= r_tx_byte[7:4];
                r_tx_have <= 1'b0;
                r_nib     <= 1'b0;
                if (!w_tx_empty) r_tx_rdreq <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            r_miso     <= 1'b1;
            r_miosi_oe <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (tx_flush) r_tx_have <= 1'b0;
    end
  end

`ifdef USB_FT1248_DEVICE_STATS_EN
  logic [15:0] r_rx_count;
  logic [15:0] r_tx_count;
  logic        w_tx_byte_done;

  // A read byte completes on the rising edge that samples its high nibble.
  assign w_tx_byte_done = (r_state == S_DATA) && (r_cmd == CMD_READ) && w_uclk_rise &&
                          !w_cs_hi && !r_nib && r_miosi_oe;

  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      r_rx_count <= '0;
      r_tx_count <= '0;
    end else begin
      if (r_rx_wrreq && !w_rx_full) r_rx_count <= r_rx_count + 16'd1;
      if (w_tx_byte_done) r_tx_count <= r_tx_count + 16'd1;
    end
  end

  assign rx_count = r_rx_count;
  assign tx_count = r_tx_count;
`else
  assign rx_count = '0;
  assign tx_count = '0;
`endif
endmodule

// File: tb/tb_usb_ft1248_device.sv
// Directed bench for usb_ft1248_device: bit-bangs the FT1248 initiator and checks hand-computed results.
module tb_usb_ft1248_device;
`ifdef USB_FT1248_DEVICE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  if_system u_sys ();

  logic        usb_clk, usb_cs, usb_miso, usb_pwren, enable;
  logic        rx_flush, rx_read, rx_empty, tx_flush, tx_write, tx_full;
  logic [7:0]  rx_rdata, tx_wdata;
  logic [15:0] rx_count, tx_count;
  logic        tb_oe;
  logic [3:0]  tb_nib;
  wire  [3:0]  miosi;

  assign miosi = tb_oe ? tb_nib : 4'bz;
  pullup (miosi[0]);
  pullup (miosi[1]);
  pullup (miosi[2]);
  pullup (miosi[3]);

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  wbuf [0:31];
  logic [7:0]  rbuf [0:7];
  logic        last_miso;
  logic [3:0]  last_nib;
  logic [3:0]  ack_nib;

  usb_ft1248_device dut (
    .sys       (u_sys),
    .usb_clk   (usb_clk),
    .usb_cs    (usb_cs),
    .usb_miso  (usb_miso),
    .usb_miosi (miosi),
    .usb_pwren (usb_pwren),
    .enable    (enable),
    .rx_flush  (rx_flush),
    .rx_read   (rx_read),
    .rx_empty  (rx_empty),
    .rx_rdata  (rx_rdata),
    .tx_flush  (tx_flush),
    .tx_write  (tx_write),
    .tx_full   (tx_full),
    .tx_wdata  (tx_wdata),
    .rx_count  (rx_count),
    .tx_count  (tx_count)
  );

  always begin
    u_sys.clk = 1'b0;
    #5;
    u_sys.clk = 1'b1;
    #5;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic half();
    repeat (6) @(negedge u_sys.clk);
  endtask

  // One usb_clk period: present data, sample device outputs just before the rising edge.
  task automatic tick(input logic drv, input logic [3:0] nib, output logic m, output logic [3:0] d);
    tb_oe  = drv;
    tb_nib = nib;
    half();
    m = usb_miso;
    d = miosi;
    usb_clk = 1'b1;
    half();
    usb_clk = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] cmd, output logic ack);
    logic       m;
    logic [3:0] d;
    usb_cs = 1'b0;
    half();
    tick(1'b1, cmd[3:0], m, d);
    tick(1'b1, cmd[7:4], m, d);
    tick(1'b0, 4'h0, m, d);
    ack       = ~m;
    ack_nib   = d;
    last_miso = m;
    last_nib  = d;
  endtask

  task automatic end_txn();
    tb_oe = 1'b0;
    half();
    usb_cs = 1'b1;
    repeat (8) @(negedge u_sys.clk);
  endtask

  task automatic usb_write(input logic [7:0] cmd, input int n, output logic ack, output int acc);
    logic       m;
    logic [3:0] d;
    start_cmd(cmd, ack);
    acc = 0;
    if (ack) begin
      for (int i = 0; i < n; i++) begin
        tick(1'b1, wbuf[i][3:0], m, d);
        last_miso = m;
        if (m) break;
        tick(1'b1, wbuf[i][7:4], m, d);
        acc++;
      end
    end
    end_txn();
  endtask

  task automatic usb_read(input logic [7:0] cmd, output logic ack, output int got);
    logic       m;
    logic [3:0] d;
    logic [3:0] lo;
    start_cmd(cmd, ack);
    got = 0;
    if (ack) begin
      for (int i = 0; i < 4; i++) begin
        tick(1'b0, 4'h0, m, d);
        last_miso = m;
        last_nib  = d;
        if (m) break;
        lo = d;
        tick(1'b0, 4'h0, m, d);
        rbuf[got] = {d, lo};
        got++;
      end
    end else begin
      tick(1'b0, 4'h0, m, d);
      last_miso = m;
      last_nib  = d;
    end
    end_txn();
  endtask

  task automatic rx_pop(output logic [7:0] b);
    @(negedge u_sys.clk);
    rx_read = 1'b1;
    @(negedge u_sys.clk);
    rx_read = 1'b0;
    @(negedge u_sys.clk);
    b = rx_rdata;
  endtask

  task automatic tx_push(input logic [7:0] b);
    @(negedge u_sys.clk);
    tx_wdata = b;
    tx_write = 1'b1;
    @(negedge u_sys.clk);
    tx_write = 1'b0;
  endtask

  initial begin
    logic       ack, m;
    logic [3:0] d;
    logic [7:0] b;
    int         n;

    u_sys.reset = 1'b1;
    usb_clk = 1'b0; usb_cs = 1'b1; enable = 1'b1;
    rx_flush = 1'b0; rx_read = 1'b0; tx_flush = 1'b0; tx_write = 1'b0; tx_wdata = '0;
    tb_oe = 1'b0; tb_nib = '0;
    repeat (5) @(negedge u_sys.clk);
    check_val("rst_miso", usb_miso, 1'b1);
    check_val("rst_pwren", usb_pwren, 1'b1);
    check_val("rst_miosi", miosi, 4'hF);
    check_val("rst_rx_empty", rx_empty, 1'b1);
    check_val("rst_tx_full", tx_full, 1'b0);
    check_val("rst_counts", {rx_count, tx_count}, 32'h0);
    u_sys.reset = 1'b0;
    repeat (3) @(negedge u_sys.clk);
    check_val("pwren_enabled", usb_pwren, 1'b0);

    // Write two bytes, low nibble first.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    usb_write(8'h00, 2, ack, n);
    check_val("wr_ack", ack, 1'b1);
    check_val("wr_accepted", n, 2);
    rx_pop(b); check_val("wr_byte0", b, 8'hA5);
    rx_pop(b); check_val("wr_byte1", b, 8'h3C);
    check_val("wr_rx_empty", rx_empty, 1'b1);
    check_val("wr_rx_count", rx_count, STATS ? 16'd2 : 16'd0);

    // Read two bytes, then the empty boundary NAKs.
    tx_push(8'h12); tx_push(8'h34);
    usb_read(8'h04, ack, n);
    check_val("rd_ack", ack, 1'b1);
    check_val("rd_count", n, 2);
    check_val("rd_byte0", rbuf[0], 8'h12);
    check_val("rd_byte1", rbuf[1], 8'h34);
    check_val("rd_end_miso", last_miso, 1'b1);
    check_val("rd_end_miosi", last_nib, 4'hF);
    check_val("rd_tx_count", tx_count, STATS ? 16'd2 : 16'd0);

    // Read with nothing queued.
    usb_read(8'h04, ack, n);
    check_val("rd_empty_ack", ack, 1'b0);
    check_val("rd_empty_turn_miosi", ack_nib, 4'hF);
    check_val("rd_empty_wait_miso", last_miso, 1'b1);
    check_val("rd_empty_wait_miosi", last_nib, 4'hF);

    // Unknown command must not touch either FIFO.
    tx_push(8'h77);
    usb_read(8'h5A, ack, n);
    check_val("bad_cmd_ack", ack, 1'b0);
    check_val("bad_cmd_wait_miso", last_miso, 1'b1);
    check_val("bad_cmd_rx_empty", rx_empty, 1'b1);

    // Device disabled: everything NAKs.
    enable = 1'b0;
    repeat (3) @(negedge u_sys.clk);
    check_val("pwren_disabled", usb_pwren, 1'b1);
    usb_write(8'h00, 1, ack, n);
    check_val("dis_wr_ack", ack, 1'b0);
    usb_read(8'h04, ack, n);
    check_val("dis_rd_ack", ack, 1'b0);
    check_val("dis_rd_miosi", ack_nib, 4'hF);
    enable = 1'b1;
    repeat (3) @(negedge u_sys.clk);

    usb_read(8'h04, ack, n);
    check_val("rd77_ack", ack, 1'b1);
    check_val("rd77_count", n, 1);
    check_val("rd77_byte", rbuf[0], 8'h77);
    check_val("rd77_tx_count", tx_count, STATS ? 16'd3 : 16'd0);

    // Abort after the low nibble of 0xF0.
    usb_cs = 1'b0;
    half();
    tick(1'b1, 4'h0, m, d);
    tick(1'b1, 4'h0, m, d);
    tick(1'b0, 4'h0, m, d);
    check_val("abort_ack", m, 1'b0);
    tick(1'b1, 4'h0, m, d);
    check_val("abort_space", m, 1'b0);
    usb_cs = 1'b1;
    repeat (3) @(posedge u_sys.clk);
    #1;
    check_val("abort_idle_miso", usb_miso, 1'b1);
    tb_oe = 1'b0;
    repeat (8) @(negedge u_sys.clk);
    check_val("abort_rx_empty", rx_empty, 1'b1);
    wbuf[0] = 8'h5C;
    usb_write(8'h00, 1, ack, n);
    check_val("post_abort_acc", n, 1);
    rx_pop(b); check_val("post_abort_byte", b, 8'h5C);

    // Fill rx to one below full, then offer two more bytes.
    for (int i = 0; i < 15; i++) wbuf[i] = 8'h10 + 8'(i);
    usb_write(8'h00, 15, ack, n);
    check_val("fill_acc", n, 15);
    wbuf[0] = 8'hE0; wbuf[1] = 8'hE1;
    usb_write(8'h00, 2, ack, n);
    check_val("full_ack", ack, 1'b1);
    check_val("full_acc", n, 1);
    check_val("full_nak_miso", last_miso, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rx_pop(b);
      check_val($sformatf("drain_%0d", i), b, (i < 15) ? 8'h10 + 8'(i) : 8'hE0);
    end
    check_val("drain_rx_empty", rx_empty, 1'b1);
    check_val("fill_rx_count", rx_count, STATS ? 16'd19 : 16'd0);

    // Flushed tx FIFO answers a read with NAK.
    tx_push(8'hAA); tx_push(8'hBB);
    @(negedge u_sys.clk); tx_flush = 1'b1;
    @(negedge u_sys.clk); tx_flush = 1'b0;
    usb_read(8'h04, ack, n);
    check_val("flush_rd_ack", ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
